// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman guess-game core.
//   state_t     : engine FSM states
//   ASCII_*     : character constants used for case folding and space detection
//   LETTERS     : size of the guessed-letter set ('A'..'Z')
package hangman_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_SCAN,
    S_EVAL,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_A     = 7'h41;
  localparam logic [6:0] ASCII_a     = 7'h61;
  localparam int         LETTERS     = 26;

endpackage

// File: rtl/letter_norm.sv
// Letter normaliser: classifies a 7-bit ASCII code and folds lower case to upper case.
// Pure combinational.
//   ascii     in   7  character to classify
//   is_letter out  1  1 for 'A'..'Z' or 'a'..'z'
//   index     out  5  letter number 0..25 (meaningless when is_letter=0)
//   upper     out  7  upper-case form of a letter; other codes pass through unchanged
module letter_norm
  import hangman_pkg::*;
(
  input  logic [6:0] ascii,
  output logic       is_letter,
  output logic [4:0] index,
  output logic [6:0] upper
);

  logic       is_upper;
  logic       is_lower;
  logic [6:0] offset;

  always_comb begin
    is_upper  = (ascii >= ASCII_A) && (ascii <= ASCII_A + 7'd25);
    is_lower  = (ascii >= ASCII_a) && (ascii <= ASCII_a + 7'd25);
    is_letter = is_upper || is_lower;
    // Lower and upper case differ only by the 0x20 offset.
    upper     = is_lower ? (ascii - (ASCII_a - ASCII_A)) : ascii;
    offset    = upper - ASCII_A;
    index     = offset[4:0];
  end

endmodule

// File: rtl/hangman_engine.sv
// Hangman guess-game core. Holds a WORD_LEN-character word, accepts letter guesses
// over valid/ready, scans the word one position per cycle and resolves WIN/LOSE.
//   clk          in   1            system clock
//   reset        in   1            synchronous, active-low reset
//   load         in   1            pulse: latch word_in and start a new round
//   word_in      in   WORD_LEN*7   packed ASCII, [6:0] = leftmost position
//   guess_valid  in   1            guess offered
//   guess_ascii  in   7            guessed character (either case)
//   guess_ready  out  1            engine accepts a guess this cycle
//   disp_ascii   out  WORD_LEN*7   revealed char or BLANK_CHAR per position
//   reveal_mask  out  WORD_LEN     1 = position revealed
//   guessed_set  out  26           bit k = letter 'A'+k already guessed
//   wrong_count  out  WRONG_W      wrong guesses this round (saturating)
//   hit/miss     out  1            result pulse for a scanned guess
//   dup/bad      out  1            pulse: repeated letter / non-letter guess
//   playing/win/lose out 1         one-hot status, all 0 when idle
module hangman_engine
  import hangman_pkg::*;
#(
  parameter int         WORD_LEN   = 7,
  parameter int         MAX_WRONG  = 6,
  parameter logic [6:0] BLANK_CHAR = 7'h5F,
  // Derived from MAX_WRONG; do not override.
  parameter int         WRONG_W    = $clog2(MAX_WRONG + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_LEN*7-1:0] word_in,
  input  logic                  guess_valid,
  input  logic [6:0]            guess_ascii,
  output logic                  guess_ready,
  output logic [WORD_LEN*7-1:0] disp_ascii,
  output logic [WORD_LEN-1:0]   reveal_mask,
  output logic [LETTERS-1:0]    guessed_set,
  output logic [WRONG_W-1:0]    wrong_count,
  output logic                  hit,
  output logic                  miss,
  output logic                  dup,
  output logic                  bad,
  output logic                  playing,
  output logic                  win,
  output logic                  lose
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [6:0]            letter, letter_d;
  logic                  hit_flag, hit_flag_d;
  logic [WORD_LEN*7-1:0] word, word_d;
  logic [WORD_LEN-1:0]   reveal_mask_d;
  logic [LETTERS-1:0]    guessed_set_d;
  logic [WRONG_W-1:0]    wrong_count_d;
  logic                  hit_d, miss_d, dup_d, bad_d;
  logic                  playing_d, win_d, lose_d, guess_ready_d;

  logic [6:0] word_chars [WORD_LEN];
  logic       norm_is_letter;
  logic [4:0] norm_index;
  logic [6:0] norm_upper;

  letter_norm u_norm (
    .ascii     (guess_ascii),
    .is_letter (norm_is_letter),
    .index     (norm_index),
    .upper     (norm_upper)
  );

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      word_chars[i]          = word[i*7 +: 7];
      disp_ascii[i*7 +: 7]   = reveal_mask[i] ? word[i*7 +: 7] : BLANK_CHAR;
    end
  end

  // Next-state and next-output logic. Every register has a *_d companion.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state;
    idx_d         = idx;
    letter_d      = letter;
    hit_flag_d    = hit_flag;
    word_d        = word;
    reveal_mask_d = reveal_mask;
    guessed_set_d = guessed_set;
    wrong_count_d = wrong_count;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    dup_d         = 1'b0;
    bad_d         = 1'b0;

    if (load) begin
      // Spaces pad short words and are shown from the start.
      word_d        = word_in;
      guessed_set_d = '0;
      wrong_count_d = '0;
      state_d       = S_PLAY;
      for (int i = 0; i < WORD_LEN; i++) begin
        reveal_mask_d[i] = (word_in[i*7 +: 7] == ASCII_SPACE);
      end
    end else begin
      unique case (state)
        S_PLAY: begin
          if (guess_valid) begin
            if (!norm_is_letter) begin
              bad_d = 1'b1;
            end else if (guessed_set[norm_index]) begin
              dup_d = 1'b1;
            end else begin
              guessed_set_d[norm_index] = 1'b1;
              letter_d   = norm_upper;
              idx_d      = '0;
              hit_flag_d = 1'b0;
              state_d    = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (word_chars[idx] == letter) begin
            reveal_mask_d[idx] = 1'b1;
            hit_flag_d         = 1'b1;
          end
          if (idx == IDX_W'(WORD_LEN - 1)) begin
            state_d = S_EVAL;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
        S_EVAL: begin
          if (hit_flag) begin
            hit_d = 1'b1;
          end else begin
            miss_d = 1'b1;
            if (wrong_count < WRONG_W'(MAX_WRONG)) begin
              wrong_count_d = wrong_count + 1'b1;
            end
          end
          // A full reveal wins even when this guess itself missed (all-space word).
          if (&reveal_mask) begin
            state_d = S_WIN;
          end else if (wrong_count_d == WRONG_W'(MAX_WRONG)) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_IDLE, S_WIN, S_LOSE: state_d = state;
        default:               state_d = S_IDLE;
      endcase
    end

    // Status is registered from the next state so it changes together with the pulses.
    guess_ready_d = (state_d == S_PLAY);
    playing_d     = (state_d == S_PLAY) || (state_d == S_SCAN) || (state_d == S_EVAL);
    win_d         = (state_d == S_WIN);
    lose_d        = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the word is an ordinary register bank rather than a RAM, so it is reset
      // like everything else and disp_ascii is defined straight out of reset.
      state       <= S_IDLE;
      idx         <= '0;
      letter      <= '0;
      hit_flag    <= 1'b0;
      word        <= '0;
      reveal_mask <= '0;
      guessed_set <= '0;
      wrong_count <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      dup         <= 1'b0;
      bad         <= 1'b0;
      playing     <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      guess_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      idx         <= idx_d;
      letter      <= letter_d;
      hit_flag    <= hit_flag_d;
      word        <= word_d;
      reveal_mask <= reveal_mask_d;
      guessed_set <= guessed_set_d;
      wrong_count <= wrong_count_d;
      hit         <= hit_d;
      miss        <= miss_d;
      dup         <= dup_d;
      bad         <= bad_d;
      playing     <= playing_d;
      win         <= win_d;
      lose        <= lose_d;
      guess_ready <= guess_ready_d;
    end
  end

endmodule
